// File: rtl/card_pkg.sv
// card_pkg: shared card codes, sprite address widths, position type and helpers
package card_pkg;
  localparam int CARD_BACK_CODE = 52;
  localparam int CODE_W = 6;
  localparam int SPRITE_ADDR_W = 18;
  typedef logic [CODE_W-1:0] card_code_t;
  typedef logic signed [11:0] pos_t;
  typedef enum logic {IDLE, SLIDE} slide_state_t;
  // linear interpolation from a toward b by frame/2^log2, floor-rounded
  function automatic pos_t slide_pos(input pos_t a, input pos_t b, input int frame, input int log2);
    int d;
    d = (int'(b) - int'(a)) * frame;
    return pos_t'(int'(a) + (d >>> log2));
  endfunction
  // face-down slots and out-of-range codes both show the card back
  function automatic card_code_t draw_code(input card_code_t raw, input logic hidden);
    return (hidden || raw > card_code_t'(CARD_BACK_CODE)) ? card_code_t'(CARD_BACK_CODE) : raw;
  endfunction
endpackage

// File: rtl/vga_if.sv
// vga_if: timing and colour bundle passed between pixel pipeline stages
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic hsync;
  logic vsync;
  logic hblnk;
  logic vblnk;
  logic [11:0] rgb;
  modport in (input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/card_slide_ctrl.sv
// card_slide_ctrl: per-frame shown-card count and deal-in slide animation
module card_slide_ctrl import card_pkg::*; #(
  parameter int NUM_SLOTS = 9,
  parameter int ROW_XPOS = 437,
  parameter int ROW_YPOS = 550,
  parameter int X_STEP = 30,
  parameter int DECK_XPOS = 900,
  parameter int DECK_YPOS = 300,
  parameter int SLIDE_LOG2 = 4
) (
  input logic clk,
  input logic rst,
  input logic tick,
  input logic [3:0] card_count,
  output logic [3:0] shown_count,
  output logic anim_busy,
  output pos_t anim_x,
  output pos_t anim_y
);
  localparam logic [SLIDE_LOG2-1:0] LAST = '1;
  slide_state_t state, state_nxt;
  logic [3:0] eff, shown_nxt;
  logic [SLIDE_LOG2-1:0] anim_frame, frame_nxt;
  pos_t x_nxt, y_nxt;
  assign anim_busy = state == SLIDE;
  // next state, count and frame; the slot being dealt is always shown_count
  always_comb begin
    eff = card_count > 4'(NUM_SLOTS) ? 4'(NUM_SLOTS) : card_count;
    state_nxt = state;
    shown_nxt = shown_count;
    frame_nxt = anim_frame;
    if (state == IDLE) begin
      if (eff > shown_count) begin
        state_nxt = SLIDE;
        frame_nxt = '0;
      end else if (eff < shown_count) shown_nxt = eff;
    end else if (eff <= shown_count) begin
      state_nxt = IDLE;
      shown_nxt = eff;
      frame_nxt = '0;
    end else if (anim_frame == LAST) begin
      state_nxt = IDLE;
      shown_nxt = shown_count + 4'd1;
      frame_nxt = '0;
    end else frame_nxt = anim_frame + 1'b1;
    x_nxt = slide_pos(pos_t'(DECK_XPOS), pos_t'(ROW_XPOS + int'(shown_nxt) * X_STEP), int'(frame_nxt), SLIDE_LOG2);
    y_nxt = slide_pos(pos_t'(DECK_YPOS), pos_t'(ROW_YPOS), int'(frame_nxt), SLIDE_LOG2);
  end
  // state and the sliding card position only move at the frame tick
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shown_count <= '0;
      anim_frame <= '0;
      anim_x <= pos_t'(DECK_XPOS);
      anim_y <= pos_t'(DECK_YPOS);
    end else if (tick) begin
      state <= state_nxt;
      shown_count <= shown_nxt;
      anim_frame <= frame_nxt;
      anim_x <= x_nxt;
      anim_y <= y_nxt;
    end
  end
endmodule

// File: rtl/card_row.sv
// card_row: overlapping row of blackjack cards drawn into the vga pixel pipeline
module card_row import card_pkg::*; #(
  parameter int NUM_SLOTS = 9,
  parameter int ROW_XPOS = 437,
  parameter int ROW_YPOS = 550,
  parameter int X_STEP = 30,
  parameter int CARD_W = 48,
  parameter int CARD_H = 64,
  parameter int DECK_XPOS = 900,
  parameter int DECK_YPOS = 300,
  parameter int SLIDE_LOG2 = 4,
  parameter int HOLE_SLOT = 15,
  parameter logic [11:0] KEY_RGB = 12'h0F0
) (
  input logic clk,
  input logic rst,
  input logic [3:0] card_count,
  input logic [NUM_SLOTS*CODE_W-1:0] card_codes,
  input logic reveal,
  vga_if.in vga_in,
  vga_if.out vga_out,
  output logic [SPRITE_ADDR_W-1:0] rom_addr,
  input logic [11:0] rom_rgb,
  output logic anim_busy
);
  logic tick, hit, hit_d, live;
  logic [3:0] shown_count;
  pos_t anim_x, anim_y;
  int dx, dy;
  logic [SPRITE_ADDR_W-1:0] addr;
  logic [10:0] hcount_d, vcount_d;
  logic hsync_d, vsync_d, hblnk_d, vblnk_d;
  logic [11:0] rgb_d;
  assign tick = vga_in.hcount == '0 && vga_in.vcount == '0;
  card_slide_ctrl #(
    .NUM_SLOTS(NUM_SLOTS), .ROW_XPOS(ROW_XPOS), .ROW_YPOS(ROW_YPOS), .X_STEP(X_STEP),
    .DECK_XPOS(DECK_XPOS), .DECK_YPOS(DECK_YPOS), .SLIDE_LOG2(SLIDE_LOG2)
  ) u_ctrl (
    .clk(clk), .rst(rst), .tick(tick), .card_count(card_count), .shown_count(shown_count),
    .anim_busy(anim_busy), .anim_x(anim_x), .anim_y(anim_y)
  );
  // hit test scanning upward so the highest visible slot overrides lower ones
  always_comb begin
    hit = 1'b0;
    addr = rom_addr;
    live = 1'b0;
    dx = 0;
    dy = 0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      live = anim_busy && i == int'(shown_count);
      dx = int'(vga_in.hcount) - (live ? int'(anim_x) : ROW_XPOS + i * X_STEP);
      dy = int'(vga_in.vcount) - (live ? int'(anim_y) : ROW_YPOS);
      if ((live || i < int'(shown_count)) && !vga_in.hblnk && !vga_in.vblnk &&
          dx >= 0 && dx < CARD_W && dy >= 0 && dy < CARD_H) begin
        hit = 1'b1;
        addr = {draw_code(card_codes[i*CODE_W +: CODE_W], i == HOLE_SLOT && !reveal), dy[5:0], dx[5:0]};
      end
    end
  end
  // two-stage pipeline: address + timing delay, then sprite-over-background select
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      hit_d <= 1'b0;
      {hcount_d, vcount_d, hsync_d, vsync_d, hblnk_d, vblnk_d, rgb_d} <= '0;
      {vga_out.hcount, vga_out.vcount, vga_out.hsync, vga_out.vsync} <= '0;
      {vga_out.hblnk, vga_out.vblnk, vga_out.rgb} <= '0;
    end else begin
      rom_addr <= addr;
      hit_d <= hit;
      {hcount_d, vcount_d, hsync_d, vsync_d} <= {vga_in.hcount, vga_in.vcount, vga_in.hsync, vga_in.vsync};
      {hblnk_d, vblnk_d, rgb_d} <= {vga_in.hblnk, vga_in.vblnk, vga_in.rgb};
      {vga_out.hcount, vga_out.vcount, vga_out.hsync, vga_out.vsync} <= {hcount_d, vcount_d, hsync_d, vsync_d};
      {vga_out.hblnk, vga_out.vblnk} <= {hblnk_d, vblnk_d};
      vga_out.rgb <= (hit_d && rom_rgb != KEY_RGB) ? rom_rgb : rgb_d;
    end
  end
endmodule
